// File: rtl/teclado_arbiter_pkg.sv
// Shared types and defaults for the keypad arbiter.
//   senhaPac_t      : packet produced by the keypad decoder (length + up to 4 BCD digits)
//   arb_state_t     : arbiter FSM states
//   DEF_*_CYC       : default timing constants
//   cnt_width()     : counter width for a modulus, never below 1 bit
package teclado_arbiter_pkg;

    typedef struct packed {
        logic [3:0]  len;
        logic [15:0] digits;
    } senhaPac_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_OP    = 2'd1,
        GRANT_SETUP = 2'd2,
        HANDOFF     = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYC = 5000;
    localparam int DEF_HANDOFF_CYC = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/teclado_arbiter_timer.sv
// Inactivity timer for the current keypad owner.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart counting from zero (grant entry or key activity)
//   enable   : count one per cycle while a grant is active
//   expired  : count has reached TIMEOUT_CYC-1
module timer_inatividade
    import teclado_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Holding at LAST keeps the counter inside its range even when
    // TIMEOUT_CYC is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/teclado_arbiter.sv
// Arbitrates one keypad decoder between an operational and a setup requester.
//   clk, rst                   : clock, synchronous active-high reset
//   req_op, req_setup          : level requests (setup wins ties and preempts op)
//   digitos_value/valid        : decoder packet + one-cycle strobe
//   teclado_en                 : decoder enable
//   grant_op, grant_setup      : current owner (one-hot or zero)
//   value_x / valid_x          : packet forwarded to owner, one cycle after input
//   timeout_x                  : one-cycle pulse when the owner is revoked for inactivity
//   dbg_state                  : arbiter FSM state
// Handshake: valid strobes carry no backpressure. A packet is transferred in the
// cycle its valid is high; value_x is meaningful then and holds otherwise.
// All visible outputs are registered from the current state, so they trail the
// state register by one cycle.
module teclado_arbiter
    import teclado_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HANDOFF_CYC = DEF_HANDOFF_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_op,
    input  logic       req_setup,
    input  senhaPac_t  digitos_value,
    input  logic       digitos_valid,
    output logic       teclado_en,
    output logic       grant_op,
    output logic       grant_setup,
    output senhaPac_t  value_op,
    output senhaPac_t  value_setup,
    output logic       valid_op,
    output logic       valid_setup,
    output logic       timeout_op,
    output logic       timeout_setup,
    output arb_state_t dbg_state
);

    localparam int HCNT_W = cnt_width(HANDOFF_CYC);
    localparam logic [HCNT_W-1:0] HLAST = HCNT_W'(HANDOFF_CYC - 1);

    arb_state_t        state, state_next, arb_pick;
    logic [HCNT_W-1:0] hcnt;
    logic              handoff_done;
    logic              lock_op, lock_setup;
    logic              elig_op, elig_setup;
    logic              in_grant;
    logic              tmr_clear, tmr_expired;
    logic              to_op, to_setup;

    logic       teclado_en_d, grant_op_d, grant_setup_d;
    logic       valid_op_d, valid_setup_d, timeout_op_d, timeout_setup_d;
    senhaPac_t  value_op_d, value_setup_d;

    // A requester revoked by timeout stays locked out until its request is seen low.
    assign elig_op      = req_op && !lock_op;
    assign elig_setup   = req_setup && !lock_setup;
    assign arb_pick     = elig_setup ? GRANT_SETUP : (elig_op ? GRANT_OP : IDLE);
    assign in_grant     = (state == GRANT_OP) || (state == GRANT_SETUP);
    assign handoff_done = (hcnt == HLAST);

    // A key in the expiry cycle counts as activity, so it cancels the timeout.
    assign to_op    = (state == GRANT_OP) && tmr_expired && !digitos_valid && req_op;
    assign to_setup = (state == GRANT_SETUP) && tmr_expired && !digitos_valid && req_setup;

    assign tmr_clear = (in_grant && digitos_valid) ||
                       (((state_next == GRANT_OP) || (state_next == GRANT_SETUP)) &&
                        (state_next != state));

    timer_inatividade #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (in_grant),
        .expired(tmr_expired)
    );

    // State register plus handoff dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_next;
            if (state != HANDOFF) begin
                hcnt <= '0;
            end else if (!handoff_done) begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:        state_next = arb_pick;
            GRANT_OP:    if (!req_op || elig_setup || to_op) state_next = HANDOFF;
            GRANT_SETUP: if (!req_setup || to_setup) state_next = HANDOFF;
            HANDOFF:     if (handoff_done) state_next = arb_pick;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_op    <= 1'b0;
            lock_setup <= 1'b0;
        end else begin
            if (to_op) lock_op <= 1'b1;
            else if (!req_op) lock_op <= 1'b0;
            if (to_setup) lock_setup <= 1'b1;
            else if (!req_setup) lock_setup <= 1'b0;
        end
    end

    // Output decode; keys arriving outside a grant (including HANDOFF) are dropped.
    always_comb begin
        teclado_en_d    = in_grant;
        grant_op_d      = (state == GRANT_OP);
        grant_setup_d   = (state == GRANT_SETUP);
        valid_op_d      = (state == GRANT_OP) && digitos_valid;
        valid_setup_d   = (state == GRANT_SETUP) && digitos_valid;
        timeout_op_d    = to_op;
        timeout_setup_d = to_setup;
        value_op_d      = valid_op_d ? digitos_value : value_op;
        value_setup_d   = valid_setup_d ? digitos_value : value_setup;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            teclado_en    <= 1'b0;
            grant_op      <= 1'b0;
            grant_setup   <= 1'b0;
            valid_op      <= 1'b0;
            valid_setup   <= 1'b0;
            timeout_op    <= 1'b0;
            timeout_setup <= 1'b0;
            value_op      <= '0;
            value_setup   <= '0;
        end else begin
            teclado_en    <= teclado_en_d;
            grant_op      <= grant_op_d;
            grant_setup   <= grant_setup_d;
            valid_op      <= valid_op_d;
            valid_setup   <= valid_setup_d;
            timeout_op    <= timeout_op_d;
            timeout_setup <= timeout_setup_d;
            value_op      <= value_op_d;
            value_setup   <= value_setup_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_teclado_arbiter.sv
module tb_teclado_arbiter;
    import teclado_arbiter_pkg::*;

    localparam int TO_CYC = 10;
    localparam int HO_CYC = 2;
    localparam int PW     = $bits(senhaPac_t);
    localparam int OUT_W  = 7 + 2 * PW;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       req_op, req_setup, digitos_valid;
    senhaPac_t  digitos_value;
    logic       teclado_en, grant_op, grant_setup;
    senhaPac_t  value_op, value_setup;
    logic       valid_op, valid_setup, timeout_op, timeout_setup;
    arb_state_t dbg_state;

    always #5 clk = ~clk;

    teclado_arbiter #(
        .TIMEOUT_CYC(TO_CYC),
        .HANDOFF_CYC(HO_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_op       (req_op),
        .req_setup    (req_setup),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid),
        .teclado_en   (teclado_en),
        .grant_op     (grant_op),
        .grant_setup  (grant_setup),
        .value_op     (value_op),
        .value_setup  (value_setup),
        .valid_op     (valid_op),
        .valid_setup  (valid_setup),
        .timeout_op   (timeout_op),
        .timeout_setup(timeout_setup),
        .dbg_state    (dbg_state)
    );

    logic [OUT_W-1:0] obs;
    assign obs = {teclado_en, grant_op, grant_setup, valid_op, valid_setup,
                  timeout_op, timeout_setup, value_op, value_setup};

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rop, input logic rsu,
                         input logic dv, input logic [PW-1:0] v);
        rst           = r;
        req_op        = rop;
        req_setup     = rsu;
        digitos_valid = dv;
        digitos_value = senhaPac_t'(v);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        check("reset_outputs", obs, '0);
        check("reset_state", dbg_state, IDLE);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rst, rop, rsu, dv;
        logic [PW-1:0]    val;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rop, input logic rsu,
                                input logic dv, input logic [PW-1:0] v,
                                input logic en, input logic gop, input logic gsu,
                                input logic vop, input logic vsu,
                                input logic top, input logic tsu,
                                input logic [PW-1:0] vo, input logic [PW-1:0] vs);
        vec_t t;
        t.rst = r; t.rop = rop; t.rsu = rsu; t.dv = dv; t.val = v;
        t.exp = {en, gop, gsu, vop, vsu, top, tsu, vo, vs};
        return t;
    endfunction

    int pulses;
    int pulse_cyc;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Row k: inputs during cycle k, outputs expected in cycle k+1.
        //               rst rop rsu dv val    en gop gsu vop vsu top tsu  value_op value_setup
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h0, 20'h0)); // 0
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h0, 20'h0)); // grant at 2
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h0, 20'h0));
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h0, 20'h0));
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h0, 20'h0));
        tbl.push_back(mk(0, 1, 0, 1, 20'h1,   1, 1, 0, 1, 0, 0, 0, 20'h1, 20'h0)); // key at 5
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h1, 20'h0)); // value holds
        tbl.push_back(mk(0, 0, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h1, 20'h0)); // release
        tbl.push_back(mk(0, 0, 0, 1, 20'h5,   0, 0, 0, 0, 0, 0, 0, 20'h1, 20'h0)); // key in handoff
        tbl.push_back(mk(0, 0, 0, 1, 20'h6,   0, 0, 0, 0, 0, 0, 0, 20'h1, 20'h0)); // key in handoff
        tbl.push_back(mk(0, 0, 1, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h1, 20'h0)); // idle, setup asks
        tbl.push_back(mk(0, 0, 1, 0, 20'h0,   1, 0, 1, 0, 0, 0, 0, 20'h1, 20'h0));
        tbl.push_back(mk(0, 0, 1, 1, 20'h3,   1, 0, 1, 0, 1, 0, 0, 20'h1, 20'h3)); // setup key
        tbl.push_back(mk(0, 1, 1, 0, 20'h0,   1, 0, 1, 0, 0, 0, 0, 20'h1, 20'h3)); // op cannot preempt
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 0, 1, 0, 0, 0, 0, 20'h1, 20'h3)); // setup release
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h1, 20'h3));
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h1, 20'h3));
        tbl.push_back(mk(0, 1, 0, 0, 20'h0,   1, 1, 0, 0, 0, 0, 0, 20'h1, 20'h3));
        tbl.push_back(mk(0, 1, 1, 1, 20'h7,   1, 1, 0, 1, 0, 0, 0, 20'h7, 20'h3)); // preempt + key
        tbl.push_back(mk(0, 1, 1, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h7, 20'h3));
        tbl.push_back(mk(0, 1, 1, 0, 20'h0,   0, 0, 0, 0, 0, 0, 0, 20'h7, 20'h3));
        tbl.push_back(mk(0, 1, 1, 0, 20'h0,   1, 0, 1, 0, 0, 0, 0, 20'h7, 20'h3)); // setup granted

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rop, tbl[i].rsu, tbl[i].dv, tbl[i].val);
            exp_q.push_back(tbl[i].exp);
            step();
            check($sformatf("vec%0d", i), obs, exp_q.pop_front());
        end

        // Simultaneous requests: setup wins, op never granted.
        do_reset();
        drive(0, 1, 1, 0, '0);
        step();
        check("tie_c1_no_grant", {grant_op, grant_setup}, 2'b00);
        step();
        check("tie_c2_setup_wins", {grant_op, grant_setup}, 2'b01);
        step();
        step();
        check("tie_c4_op_still_out", {grant_op, grant_setup}, 2'b01);

        // Inactivity timeout with lockout, then regrant after req_op dips.
        do_reset();
        drive(0, 1, 0, 0, '0);
        pulses    = 0;
        pulse_cyc = -1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (timeout_op) begin
                pulses++;
                pulse_cyc = k;
            end
            check($sformatf("to_grant_c%0d", k), grant_op, (k >= 2 && k <= 11));
        end
        check("to_pulse_count", pulses, 1);
        check("to_pulse_cycle", pulse_cyc, 11);
        drive(0, 0, 0, 0, '0);
        step();
        drive(0, 1, 0, 0, '0);
        step();
        check("to_regrant_c27", grant_op, 1'b0);
        step();
        check("to_regrant_c28", grant_op, 1'b1);

        // Reset during a setup grant with a key in flight.
        do_reset();
        drive(0, 0, 1, 0, '0);
        step();
        check("rst_first_edge_no_grant", grant_setup, 1'b0);
        step();
        check("rst_grant_setup", grant_setup, 1'b1);
        drive(0, 0, 1, 1, 20'h9);
        step();
        check("rst_pre_value", {valid_setup, value_setup}, {1'b1, 20'h9});
        drive(1, 0, 1, 1, 20'hA);
        step();
        check("rst_mid_grant_outputs", obs, '0);
        check("rst_mid_grant_state", dbg_state, IDLE);
        drive(0, 0, 1, 0, '0);
        step();
        check("rst_after_c1", grant_setup, 1'b0);
        step();
        check("rst_after_c2", grant_setup, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/teclado_arbiter.md
TECLADO_ARBITER -- requirements
Module: teclado_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 5000, cycles of keypad inactivity before the grant is revoked (5 s at clk_div).
REQ-002 Parameter HANDOFF_CYC, default 2, cycles with the keypad disabled between two grants.
REQ-003 clk  in  1  system clock (clk_div domain); single clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_op  in  1  operational requester wants the keypad (level).
REQ-006 req_setup  in  1  setup requester wants the keypad (level).
REQ-007 digitos_value  in  senhaPac_t  packet from keypad decoder.
REQ-008 digitos_valid  in  1  one-cycle strobe qualifying digitos_value.
REQ-009 teclado_en  out  1  enable to keypad decoder.
REQ-010 grant_op, grant_setup  out  1 each  current owner; never both high.
REQ-011 value_op, value_setup  out  senhaPac_t  registered packet for each requester.
REQ-012 valid_op, valid_setup  out  1 each  one-cycle strobe qualifying the matching value.
REQ-013 timeout_op, timeout_setup  out  1 each  one-cycle pulse on inactivity revocation.

Function
REQ-014 All outputs shall be registered; states IDLE, GRANT_OP, GRANT_SETUP, HANDOFF.
REQ-015 IDLE: teclado_en=0, grants=0; next cycle -> GRANT_SETUP if req_setup eligible, else GRANT_OP if req_op eligible, else stay.
REQ-016 Simultaneous eligible requests: setup shall win.
REQ-017 GRANT_x: teclado_en=1, grant_x=1; digitos_valid forwarded as valid_x with value_x exactly 1 cycle later; the non-owner's valid shall stay 0.
REQ-018 Release: req of owner low -> HANDOFF next cycle.
REQ-019 Preemption: in GRANT_OP with req_setup high -> HANDOFF next cycle; a digitos_valid in that same cycle is still delivered to op.
REQ-020 Inactivity counter: cleared on grant entry and on each digitos_valid, +1 per GRANT cycle; at TIMEOUT_CYC-1 pulse timeout_x for 1 cycle and go to HANDOFF.
REQ-021 Lockout: a requester revoked by timeout is ineligible until its req has been observed low for at least one cycle.
REQ-022 HANDOFF: teclado_en=0, grants=0, digitos_valid dropped (no valid out); lasts exactly HANDOFF_CYC cycles, then arbitrates as IDLE in the next cycle.
REQ-023 Counter width shall be $clog2(TIMEOUT_CYC) bits, saturating never reached (wrap impossible by REQ-020).
REQ-024 value_x shall hold its last value when valid_x is 0.

Reset
REQ-025 rst high in any state, including mid-grant or mid-handoff: next edge -> IDLE, teclado_en=0, all grants/valids/timeouts 0, values 0, counters 0, lockouts cleared.
REQ-026 First grant after rst deassert shall occur no earlier than the second edge with rst low.

Structure
REQ-027 arb_state_t enum and default TIMEOUT/HANDOFF constants shall live in the shared package beside senhaPac_t.
REQ-028 Inactivity counter shall be one sub-module, timer_inatividade (clear, enable, expired).

Verification
REQ-029 TIMEOUT_CYC=10, HANDOFF_CYC=2: req_op=1 at cycle 0 -> grant_op=1, teclado_en=1 at cycle 2; digitos_valid at cycle 5 value 0x1 -> valid_op=1, value_op=0x1 at cycle 6, valid_setup=0.
REQ-030 req_op and req_setup both rise at cycle 0 -> grant_setup at cycle 2, grant_op stays 0.
REQ-031 grant_op held, req_setup rises at cycle 20 with digitos_valid -> valid_op at 21, HANDOFF 21-22, grant_setup at 24.
REQ-032 grant_op, no keys for 10 cycles -> timeout_op single pulse, grant_op drops; req_op kept high -> no regrant; req_op low 1 cycle then high -> regrant.
REQ-033 rst pulsed during GRANT_SETUP with digitos_valid -> next cycle all outputs 0, no valid_setup emitted.
REQ-034 digitos_valid during HANDOFF -> no valid_op/valid_setup ever produced for it.
